// File: rtl/gopigo3_spi_pkg.sv
// rtl/gopigo3_spi_pkg.sv - GoPiGo3 SPI protocol constants, frame lengths and state enum
// Purpose: shared definitions for the GoPiGo3 SPI responder and its controller.
// Ports: none (package).
package gopigo3_spi_pkg;

  localparam logic [7:0] G_ADDR = 8'h08;

  localparam logic [7:0] MSG_SET_LED          = 8'd6;
  localparam logic [7:0] MSG_SET_SERVO        = 8'd9;
  localparam logic [7:0] MSG_SET_MOTOR_DPS    = 8'd14;
  localparam logic [7:0] MSG_SET_MOTOR_LIMITS = 8'd15;
  localparam logic [7:0] MSG_GET_ENC_LEFT     = 8'd17;
  localparam logic [7:0] MSG_GET_ENC_RGHT     = 8'd18;

  localparam logic [7:0] PORT_LED_EYE_LEFT   = 8'h02;
  localparam logic [7:0] PORT_LED_EYE_RGHT   = 8'h01;
  localparam logic [7:0] PORT_LED_BLINK_LEFT = 8'h04;
  localparam logic [7:0] PORT_LED_BLINK_RGHT = 8'h08;
  localparam logic [7:0] PORT_SERVO_1        = 8'h01;
  localparam logic [7:0] PORT_SERVO_2        = 8'h02;
  localparam logic [7:0] PORT_MOTOR_LEFT     = 8'h01;
  localparam logic [7:0] PORT_MOTOR_RGHT     = 8'h02;

  localparam logic [7:0] GET_MARKER = 8'hA5;

  localparam logic [3:0] LEN_SET_LED          = 4'd6;
  localparam logic [3:0] LEN_SET_SERVO        = 4'd5;
  localparam logic [3:0] LEN_SET_MOTOR_LIMITS = 4'd6;
  localparam logic [3:0] LEN_SET_MOTOR_DPS    = 4'd5;
  localparam logic [3:0] LEN_GET_ENC          = 4'd8;

  localparam logic [15:0] SERVO_RESET_US = 16'd1500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  // Total frame length in bytes; 0 marks an unknown message type.
  function automatic logic [3:0] frame_len(input logic [7:0] cmd);
    case (cmd)
      MSG_SET_LED:          frame_len = LEN_SET_LED;
      MSG_SET_SERVO:        frame_len = LEN_SET_SERVO;
      MSG_SET_MOTOR_LIMITS: frame_len = LEN_SET_MOTOR_LIMITS;
      MSG_SET_MOTOR_DPS:    frame_len = LEN_SET_MOTOR_DPS;
      MSG_GET_ENC_LEFT:     frame_len = LEN_GET_ENC;
      MSG_GET_ENC_RGHT:     frame_len = LEN_GET_ENC;
      default:              frame_len = 4'd0;
    endcase
  endfunction

  function automatic logic is_get(input logic [7:0] cmd);
    is_get = (cmd == MSG_GET_ENC_LEFT) || (cmd == MSG_GET_ENC_RGHT);
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI mode-0 slave bit engine with pin synchronisers
// Purpose: synchronise SPI pins, detect edges, shift rx/tx bytes, strobe byte/frame events.
// Ports: clk/rst; sclk_i, mosi_i, spi_ss_n_i raw pins; tx_load_i next reply byte;
//        miso_o, miso_en_o; rx_byte_o, bit_cnt_o; byte_done_o, sclk_edge_o,
//        ss_fall_o, ss_rise_o one-clock strobes.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       spi_ss_n_i,
  input  logic [7:0] tx_load_i,
  output logic       miso_o,
  output logic       miso_en_o,
  output logic [7:0] rx_byte_o,
  output logic [2:0] bit_cnt_o,
  output logic       byte_done_o,
  output logic       sclk_edge_o,
  output logic       ss_fall_o,
  output logic       ss_rise_o
);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic       armed_q, armed_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, fall_cnt_q, fall_cnt_d;
  logic       byte_done_q, byte_done_d, sclk_edge_q, sclk_edge_d;
  logic       ss_fall_q, ss_fall_d, ss_rise_q, ss_rise_d;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Index 1 is the synchronised value, index 2 its one-clock delay for edge detect.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  // ss edges are only honoured once ss_n has been seen high after reset, so a
  // frame already in progress when reset drops is ignored until the next fall.
  assign ss_fall   = armed_q & ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise   = armed_q & ss_sync_q[1] & ~ss_sync_q[2];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk_i};
    mosi_sync_d = {mosi_sync_q[0], mosi_i};
    ss_sync_d   = {ss_sync_q[1:0], spi_ss_n_i};
    armed_d     = armed_q | ss_sync_q[1];
    rx_d        = rx_q;
    tx_d        = tx_q;
    bit_cnt_d   = bit_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    byte_done_d = 1'b0;
    sclk_edge_d = sclk_rise | sclk_fall;
    ss_fall_d   = ss_fall;
    ss_rise_d   = ss_rise;
    if (ss_fall) begin
      bit_cnt_d  = 3'd0;
      fall_cnt_d = 3'd0;
      tx_d       = 8'h00;
    end else begin
      if (sclk_rise) begin
        rx_d        = {rx_q[6:0], mosi_sync_q[1]};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        byte_done_d = (bit_cnt_q == 3'd7);
      end
      if (sclk_fall) begin
        // The 8th fall of a byte presents the MSB of the next reply byte.
        tx_d       = (fall_cnt_q == 3'd7) ? tx_load_i : {tx_q[6:0], 1'b0};
        fall_cnt_d = fall_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 3'b000;
      armed_q     <= 1'b0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      fall_cnt_q  <= 3'd0;
      byte_done_q <= 1'b0;
      sclk_edge_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      armed_q     <= armed_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      byte_done_q <= byte_done_d;
      sclk_edge_q <= sclk_edge_d;
      ss_fall_q   <= ss_fall_d;
      ss_rise_q   <= ss_rise_d;
    end
  end

  assign miso_o      = tx_q[7];
  assign miso_en_o   = armed_q & ~ss_sync_q[1];
  assign rx_byte_o   = rx_q;
  assign bit_cnt_o   = bit_cnt_q;
  assign byte_done_o = byte_done_q;
  assign sclk_edge_o = sclk_edge_q;
  assign ss_fall_o   = ss_fall_q;
  assign ss_rise_o   = ss_rise_q;

endmodule

// File: rtl/gopigo3_spi_responder.sv
// rtl/gopigo3_spi_responder.sv - GoPiGo3 board-side SPI responder
// Purpose: decode GoPiGo3 SET frames into latched outputs, answer encoder GET frames.
// Ports: clk/rst; SPI pins sclk_i, mosi_i, spi_ss_n_i, miso_o, miso_en_o;
//        motor_ticks_*_i encoder inputs; motor/LED/servo command outputs;
//        set_stb_o/set_cmd_o commit report; frame_err_o discard report.
module gopigo3_spi_responder
  import gopigo3_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        mosi_i,
  input  logic        spi_ss_n_i,
  output logic        miso_o,
  output logic        miso_en_o,
  input  logic [31:0] motor_ticks_left_i,
  input  logic [31:0] motor_ticks_rght_i,
  output logic [15:0] motor_dps_left_o,
  output logic [15:0] motor_dps_rght_o,
  output logic [15:0] motor_dps_limit_o,
  output logic [23:0] led_eye_left_rgb_o,
  output logic [23:0] led_eye_rght_rgb_o,
  output logic [23:0] led_blink_left_rgb_o,
  output logic [23:0] led_blink_rght_rgb_o,
  output logic [15:0] servo_1_o,
  output logic [15:0] servo_2_o,
  output logic        set_stb_o,
  output logic [7:0]  set_cmd_o,
  output logic        frame_err_o
);

  logic [7:0] rx_byte, tx_load;
  logic [2:0] bit_cnt;
  logic       byte_done, sclk_edge, ss_fall, ss_rise;

  spi_slave_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk_i),
    .mosi_i     (mosi_i),
    .spi_ss_n_i (spi_ss_n_i),
    .tx_load_i  (tx_load),
    .miso_o     (miso_o),
    .miso_en_o  (miso_en_o),
    .rx_byte_o  (rx_byte),
    .bit_cnt_o  (bit_cnt),
    .byte_done_o(byte_done),
    .sclk_edge_o(sclk_edge),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise)
  );

  spi_state_e  state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        saw_edge_q, saw_edge_d;
  logic [31:0] stage_q, stage_d, snap_q, snap_d;
  logic [15:0] dps_l_q, dps_l_d, dps_r_q, dps_r_d, limit_q, limit_d;
  logic [23:0] eye_l_q, eye_l_d, eye_r_q, eye_r_d, blink_l_q, blink_l_d, blink_r_q, blink_r_d;
  logic [15:0] servo1_q, servo1_d, servo2_q, servo2_d;
  logic        set_stb_q, set_stb_d, frame_err_q, frame_err_d;
  logic [7:0]  set_cmd_q, set_cmd_d;

  // Reply byte for the byte about to start; byte_cnt_q already counts the one just finished.
  always_comb begin
    tx_load = 8'h00;
    if (state_q == ST_DATA && is_get(cmd_q)) begin
      case (byte_cnt_q)
        4'd3:    tx_load = GET_MARKER;
        4'd4:    tx_load = snap_q[31:24];
        4'd5:    tx_load = snap_q[23:16];
        4'd6:    tx_load = snap_q[15:8];
        4'd7:    tx_load = snap_q[7:0];
        default: tx_load = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    cmd_d       = cmd_q;
    saw_edge_d  = saw_edge_q;
    stage_d     = stage_q;
    snap_d      = snap_q;
    dps_l_d     = dps_l_q;
    dps_r_d     = dps_r_q;
    limit_d     = limit_q;
    eye_l_d     = eye_l_q;
    eye_r_d     = eye_r_q;
    blink_l_d   = blink_l_q;
    blink_r_d   = blink_r_q;
    servo1_d    = servo1_q;
    servo2_d    = servo2_q;
    set_cmd_d   = set_cmd_q;
    set_stb_d   = 1'b0;
    frame_err_d = 1'b0;
    if (ss_fall) begin
      state_d    = ST_ADDR;
      byte_cnt_d = 4'd0;
      saw_edge_d = 1'b0;
    end else if (ss_rise) begin
      if (state_q != ST_IDLE && saw_edge_q) begin
        if (state_q == ST_DATA && byte_cnt_q == frame_len(cmd_q) && bit_cnt == 3'd0) begin
          if (!is_get(cmd_q)) begin
            set_stb_d = 1'b1;
            set_cmd_d = cmd_q;
            // Staging holds the last four data bytes; 16-bit values are always the last two.
            case (cmd_q)
              MSG_SET_LED: begin
                if ((stage_q[31:24] & PORT_LED_EYE_LEFT) != 8'h00)   eye_l_d   = stage_q[23:0];
                if ((stage_q[31:24] & PORT_LED_EYE_RGHT) != 8'h00)   eye_r_d   = stage_q[23:0];
                if ((stage_q[31:24] & PORT_LED_BLINK_LEFT) != 8'h00) blink_l_d = stage_q[23:0];
                if ((stage_q[31:24] & PORT_LED_BLINK_RGHT) != 8'h00) blink_r_d = stage_q[23:0];
              end
              MSG_SET_SERVO: begin
                if ((stage_q[23:16] & PORT_SERVO_1) != 8'h00) servo1_d = stage_q[15:0];
                if ((stage_q[23:16] & PORT_SERVO_2) != 8'h00) servo2_d = stage_q[15:0];
              end
              MSG_SET_MOTOR_DPS: begin
                if ((stage_q[23:16] & PORT_MOTOR_LEFT) != 8'h00) dps_l_d = stage_q[15:0];
                if ((stage_q[23:16] & PORT_MOTOR_RGHT) != 8'h00) dps_r_d = stage_q[15:0];
              end
              default: limit_d = stage_q[15:0];
            endcase
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      if (sclk_edge) saw_edge_d = 1'b1;
      if (byte_done) begin
        if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
        case (state_q)
          ST_ADDR: state_d = (rx_byte == G_ADDR) ? ST_CMD : ST_IGNORE;
          ST_CMD: begin
            cmd_d   = rx_byte;
            state_d = (frame_len(rx_byte) != 4'd0) ? ST_DATA : ST_IGNORE;
            if (rx_byte == MSG_GET_ENC_LEFT) snap_d = motor_ticks_left_i;
            if (rx_byte == MSG_GET_ENC_RGHT) snap_d = motor_ticks_rght_i;
          end
          ST_DATA: stage_d = {stage_q[23:0], rx_byte};
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 4'd0;
      cmd_q       <= 8'h00;
      saw_edge_q  <= 1'b0;
      stage_q     <= 32'h0;
      snap_q      <= 32'h0;
      dps_l_q     <= 16'h0;
      dps_r_q     <= 16'h0;
      limit_q     <= 16'h0;
      eye_l_q     <= 24'h0;
      eye_r_q     <= 24'h0;
      blink_l_q   <= 24'h0;
      blink_r_q   <= 24'h0;
      servo1_q    <= SERVO_RESET_US;
      servo2_q    <= SERVO_RESET_US;
      set_cmd_q   <= 8'h00;
      set_stb_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_q       <= cmd_d;
      saw_edge_q  <= saw_edge_d;
      stage_q     <= stage_d;
      snap_q      <= snap_d;
      dps_l_q     <= dps_l_d;
      dps_r_q     <= dps_r_d;
      limit_q     <= limit_d;
      eye_l_q     <= eye_l_d;
      eye_r_q     <= eye_r_d;
      blink_l_q   <= blink_l_d;
      blink_r_q   <= blink_r_d;
      servo1_q    <= servo1_d;
      servo2_q    <= servo2_d;
      set_cmd_q   <= set_cmd_d;
      set_stb_q   <= set_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign motor_dps_left_o     = dps_l_q;
  assign motor_dps_rght_o     = dps_r_q;
  assign motor_dps_limit_o    = limit_q;
  assign led_eye_left_rgb_o   = eye_l_q;
  assign led_eye_rght_rgb_o   = eye_r_q;
  assign led_blink_left_rgb_o = blink_l_q;
  assign led_blink_rght_rgb_o = blink_r_q;
  assign servo_1_o            = servo1_q;
  assign servo_2_o            = servo2_q;
  assign set_stb_o            = set_stb_q;
  assign set_cmd_o            = set_cmd_q;
  assign frame_err_o          = frame_err_q;

endmodule
